telem_frame_writer: RTL and testbench
=====================================

Name: telem_frame_writer

Overview:
- Sequencer/arbiter in front of the telemetry coordinate register bank.
- The bank holds NSLOT slots of 4 coordinate bytes each, in the order X, Y, Z, T, one-hot addressed through the telemetry decoder.
- Up to NREQ sensor requesters submit whole 32-bit frames targeted at a slot. The block arbitrates round-robin and writes the frame one byte per cycle into the bank.
- Also provides a bulk clear sweep that zeroes the whole bank.

Parameters:
- NREQ, default 4: number of requesters.
- NSLOT, default 8: number of coordinate slots; NSLOT*4 must be ≤ 32 (decoder reach).
- SW, default 3: slot index width, equal to clog2(NSLOT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester frame valid.
- req_slot  in  NREQ*SW  per-requester target slot; requester i uses bits [i*SW +: SW].
- req_frame  in  NREQ*32  per-requester frame; requester i uses bits [i*32 +: 32], with X=[7:0], Y=[15:8], Z=[23:16], T=[31:24].
- req_ready  out  NREQ  one-cycle accept pulse, at most one bit high.
- clr_req  in  1  request for a bank clear sweep (level).
- wr_en  out  1  decoder enable / mux load select.
- wr_addr  out  8  decoder target index.
- wr_data  out  8  byte to load into the addressed register.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame's 4 bytes have all been written.
- done_id  out  clog2(NREQ)  id of the requester whose frame completed; valid only while frame_done is high.
- clr_done  out  1  one-cycle pulse at the end of a clear sweep.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0; rr_ptr=0; beat and sweep counters 0.
  - Any in-flight frame or sweep is abandoned. A frame already accepted is lost; the sensor must resend.
- States: IDLE, WRITE, DONE, CLEAR, CDONE.
- IDLE:
  - If clr_req=1: go to CLEAR, sweep counter=0. Clear wins over any req_valid in the same cycle.
  - Else if any req_valid bit is set: grant the first set bit searching upward from rr_ptr, with wrap-around.
  - On a grant: req_ready[g]=1 this cycle (combinational from state/valid); latch slot, frame and g; beat=0; go to WRITE; rr_ptr becomes (g+1) mod NREQ.
  - Else stay in IDLE.
- WRITE, beats 0..3, one per cycle:
  - wr_en=1.
  - wr_addr = slot*4 + beat, zero-extended to 8 bits.
  - wr_data = latched frame[beat*8 +: 8].
  - After beat 3, go to DONE.
- DONE:
  - frame_done=1, done_id=g, wr_en=0.
  - Next state is IDLE, so a new grant is possible on the following cycle.
- CLEAR:
  - wr_en=1, wr_data=0, wr_addr=counter.
  - Counter runs 0 .. NSLOT*4-1, one address per cycle; then go to CDONE.
  - clr_req is ignored during the sweep.
- CDONE: clr_done=1 for one cycle; then IDLE.
- Latency and throughput:
  - Accept to first write: 1 cycle.
  - Accept to frame_done: 5 cycles.
  - Sustained throughput: one frame per 6 cycles.
  - Sweep length: NSLOT*4 write cycles, plus 1 for CDONE.
- Handshake rules:
  - A requester holds valid, slot and frame stable until it sees ready.
  - Deasserting valid before ready is allowed; no commitment has been made.
  - Data is sampled only in the ready cycle; later changes on the inputs have no effect.
- Boundary conditions:
  - Two requesters targeting the same slot: frames are written in grant order; the last writer wins.
  - A single requester holding valid continuously gets a grant every 6 cycles.
  - Outside WRITE and CLEAR: wr_en=0, wr_addr=0, wr_data=0.
- All outputs are registered except req_ready.

Decomposition:
- Shared package holds:
  - coordinate byte order constants COORD_X=0, COORD_Y=1, COORD_Z=2, COORD_T=3;
  - COORDS_PER_SLOT=4;
  - state encoding localparams.
- One natural sub-module: telem_rr_arbiter (NREQ-bit request vector and rr_ptr in; one-hot grant and encoded index out; combinational only).

Test Plan:
- Reset mid-WRITE: req0 slot=2 frame=0x44332211, assert rst at beat 1 -> all outputs 0 immediately; no further writes; next grant goes to req0 (rr_ptr=0).
- Single frame: req0 slot=2 frame=0x44332211 -> ready0 pulse; then writes (8,0x11), (9,0x22), (10,0x33), (11,0x44) on consecutive cycles; frame_done with done_id=0 on the 5th cycle after accept.
- Round-robin: req0..req3 all valid from reset -> grants in order 0,1,2,3,0; accepts spaced exactly 6 cycles apart.
- Clear priority: clr_req and req1 valid in the same IDLE cycle -> 32 writes of 0 to addresses 0..31, then clr_done; req1 granted in the cycle after CDONE.
- Same-slot collision: req1 slot=7 frame=0xAAAAAAAA and req2 slot=7 frame=0xBBBBBBBB -> addresses 28..31 end holding 0xBB.
- Valid withdrawn: req3 valid for 1 cycle while the block is busy, then dropped -> no ready3 pulse and no write for req3.

Source files
------------

// File: rtl/telem_frame_writer_pkg.sv
// Shared constants and types for the telemetry frame writer: coordinate byte
// order, slot geometry and FSM state encoding.
package telem_frame_writer_pkg;

    localparam int unsigned COORD_X         = 0;
    localparam int unsigned COORD_Y         = 1;
    localparam int unsigned COORD_Z         = 2;
    localparam int unsigned COORD_T         = 3;
    localparam int unsigned COORDS_PER_SLOT = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_CDONE = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StWrite = ST_WRITE,
        StDone  = ST_DONE,
        StClear = ST_CLEAR,
        StCdone = ST_CDONE
    } state_e;

    // Byte `beat` of a frame, X in the low byte.
    function automatic logic [7:0] coord_byte(input logic [31:0] frame, input logic [1:0] beat);
        logic [31:0] sh;
        sh = frame >> {beat, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/telem_frame_writer_if.sv
// Requester handshake and register-bank write bus of the telemetry frame writer.
interface telem_frame_writer_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned SW   = 3,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*SW-1:0] req_slot;
    logic [NREQ*32-1:0] req_frame;
    logic [NREQ-1:0]    req_ready;
    logic               clr_req;
    logic               wr_en;
    logic [7:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               busy;
    logic               frame_done;
    logic [IW-1:0]      done_id;
    logic               clr_done;

    modport master (
        output req_valid, req_slot, req_frame, clr_req,
        input  req_ready, wr_en, wr_addr, wr_data, busy, frame_done, done_id, clr_done
    );

    modport slave (
        input  req_valid, req_slot, req_frame, clr_req,
        output req_ready, wr_en, wr_addr, wr_data, busy, frame_done, done_id, clr_done
    );
endinterface

// File: rtl/telem_frame_writer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i,
// wrapping around.
module telem_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    int unsigned       pos;

    always_comb begin
        // Rotate so that the requester at ptr_i sits at bit 0.
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[NREQ-1:0];
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = i + 32'(ptr_i);
            end
        end
        if (pos >= NREQ) pos = pos - NREQ;
        idx_o = IW'(pos);
        gnt_o = found ? (NREQ'(1) << pos) : '0;
    end

    assign valid_o = found;

endmodule

// File: rtl/telem_frame_writer.sv
// Sequencer in front of the telemetry coordinate bank: arbitrates whole
// frames round-robin, writes them a byte per cycle, and runs bank clears.
module telem_frame_writer
    import telem_frame_writer_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NSLOT = 8,
    parameter int unsigned SW    = 3
) (
    input logic              clk,
    input logic              rst,
    telem_frame_writer_if.slave bus
);

    localparam int unsigned IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NADDR = NSLOT * COORDS_PER_SLOT;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0]    beat_q, beat_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [31:0]   frame_q, frame_d;
    logic [IW-1:0] id_q, id_d;

    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic [IW-1:0] done_id_q, done_id_d;
    logic          clr_done_q, clr_done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [NREQ-1:0] ready;

    telem_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        frame_d  = frame_q;
        id_d     = id_q;
        ready    = '0;

        unique case (state_q)
            StIdle: begin
                // Clear has priority; rst gates ready so no grant leaks out of reset.
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (arb_valid && !rst) begin
                    ready    = arb_gnt;
                    slot_d   = bus.req_slot[32'(arb_idx)*SW +: SW];
                    frame_d  = bus.req_frame[32'(arb_idx)*32 +: 32];
                    id_d     = arb_idx;
                    beat_d   = '0;
                    state_d  = StWrite;
                    rr_ptr_d = (32'(arb_idx) == NREQ - 1) ? '0 : IW'(arb_idx + 1'b1);
                end
            end
            StWrite: begin
                if (beat_q == 2'd3) state_d = StDone;
                else                beat_d  = beat_q + 2'd1;
            end
            StDone:  state_d = StIdle;
            StClear: begin
                if (cnt_q == 8'(NADDR - 1)) state_d = StCdone;
                else                        cnt_d   = cnt_q + 8'd1;
            end
            StCdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        frame_done_d = 1'b0;
        done_id_d    = '0;
        clr_done_d   = 1'b0;
        unique case (state_d)
            StWrite: begin
                wr_en_d   = 1'b1;
                wr_addr_d = 8'(slot_d) * 8'(COORDS_PER_SLOT) + 8'(beat_d);
                wr_data_d = coord_byte(frame_d, beat_d);
            end
            StDone: begin
                frame_done_d = 1'b1;
                done_id_d    = id_d;
            end
            StClear: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_d;
            end
            StCdone: clr_done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            slot_q       <= '0;
            frame_q      <= '0;
            id_q         <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_id_q    <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            frame_q      <= frame_d;
            id_q         <= id_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            done_id_q    <= done_id_d;
            clr_done_q   <= clr_done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.done_id    = done_id_q;
    assign bus.clr_done   = clr_done_q;

endmodule

// File: tb/tb_telem_frame_writer.sv
// Directed bench for telem_frame_writer: reset, single frame, round-robin,
// clear priority, withdrawn request and same-slot collision.
module tb_telem_frame_writer;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned NSLOT = 8;
    localparam int unsigned SW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    telem_frame_writer_if #(.NREQ(NREQ), .SW(SW)) bus ();

    telem_frame_writer #(
        .NREQ  (NREQ),
        .NSLOT (NSLOT),
        .SW    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int slot4_writes = 0;
    int rdy3_cnt = 0;
    logic [7:0] bank [32];

    // Bank model built from observed writes; ready3 and slot-4 write counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en) begin
            bank[bus.wr_addr[4:0]] <= bus.wr_data;
            if (bus.wr_addr >= 8'd16 && bus.wr_addr < 8'd20) slot4_writes <= slot4_writes + 1;
        end
        if (bus.req_ready[3]) rdy3_cnt <= rdy3_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [7:0] a,
                          input logic [7:0] d);
        chk({tag, ".en"}, 32'(bus.wr_en), 32'(en));
        chk({tag, ".addr"}, 32'(bus.wr_addr), 32'(a));
        chk({tag, ".data"}, 32'(bus.wr_data), 32'(d));
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] s, input logic [31:0] f);
        bus.req_valid[i]          = v;
        bus.req_slot[i*SW +: SW]  = s;
        bus.req_frame[i*32 +: 32] = f;
    endtask

    // Called at negedge+1; returns at the negedge+1 where ready is seen.
    task automatic wait_ready(input string tag, input logic [3:0] exp, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (bus.req_ready != 4'b0) break;
            @(negedge clk); #1;
        end
        chk(tag, 32'(bus.req_ready), 32'(exp));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!bus.busy) break;
            @(negedge clk); #1;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] f;
        int last;
        int r3_before;
        int w4_before;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_slot  = '0;
        bus.req_frame = '0;
        bus.clr_req   = 1'b0;

        // Reset state, with requests pending to show ready stays low.
        repeat (2) @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        chk_wr("reset", 1'b0, 8'd0, 8'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.frame_done", 32'(bus.frame_done), 32'd0);
        chk("reset.clr_done", 32'(bus.clr_done), 32'd0);
        chk("reset.done_id", 32'(bus.done_id), 32'd0);
        chk("reset.ready", 32'(bus.req_ready), 32'd0);

        // Reset in the middle of a write.
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        set_req(0, 1'b1, 3'd2, 32'h44332211);
        #1 chk("rmw.ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        set_req(0, 1'b0, 3'd2, 32'h44332211);
        #1 chk_wr("rmw.b0", 1'b1, 8'd8, 8'h11);
        @(negedge clk); #1;
        chk_wr("rmw.b1", 1'b1, 8'd9, 8'h22);
        rst = 1'b1;
        #1 chk_wr("rmw.rst", 1'b0, 8'd0, 8'd0);
        chk("rmw.busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rmw.nowrite", 32'(bus.wr_en), 32'd0);
        @(negedge clk); #1;
        chk("rmw.nowrite2", 32'(bus.wr_en), 32'd0);

        // Single frame; req1 also valid but rr_ptr restarted at 0.
        @(negedge clk);
        set_req(0, 1'b1, 3'd2, 32'h44332211);
        set_req(1, 1'b1, 3'd6, 32'h12345678);
        #1 chk("single.ready", 32'(bus.req_ready), 32'b0001);
        f = 32'h44332211;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin
                set_req(0, 1'b0, 3'd5, 32'hFFFFFFFF);
                set_req(1, 1'b0, 3'd6, 32'h12345678);
            end
            #1 chk_wr($sformatf("single.b%0d", b), 1'b1, 8'(8 + b), f[b*8 +: 8]);
        end
        @(negedge clk); #1;
        chk("single.done", 32'(bus.frame_done), 32'd1);
        chk("single.done_id", 32'(bus.done_id), 32'd0);
        chk("single.done_wren", 32'(bus.wr_en), 32'd0);
        chk("single.done_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        chk("single.done_pulse", 32'(bus.frame_done), 32'd0);
        chk("single.idle", 32'(bus.busy), 32'd0);

        // Round robin from reset with all four requesters valid.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), {4{8'(i + 1)}});
        #1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ready($sformatf("rr.grant%0d", k), 4'(1 << (k % 4)), 12);
            if (k > 0) chk($sformatf("rr.gap%0d", k), 32'(cyc - last), 32'd6);
            last = cyc;
            @(negedge clk); #1;
        end
        bus.req_valid = '0;
        wait_idle("rr.idle", 12);

        // Clear wins over a simultaneous request; req1 follows after CDONE.
        @(negedge clk);
        bus.clr_req = 1'b1;
        set_req(1, 1'b1, 3'd5, 32'hCAFEF00D);
        #1 chk("clr.ready", 32'(bus.req_ready), 32'd0);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            if (a == 0) bus.clr_req = 1'b0;
            #1 chk_wr($sformatf("clr.a%0d", a), 1'b1, 8'(a), 8'd0);
            if (a == 0) chk("clr.busy_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk); #1;
        chk("clr.cdone", 32'(bus.clr_done), 32'd1);
        chk("clr.cdone_wren", 32'(bus.wr_en), 32'd0);
        chk("clr.cdone_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        chk("clr.cdone_pulse", 32'(bus.clr_done), 32'd0);
        chk("clr.req1_ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        set_req(1, 1'b0, 3'd5, 32'hCAFEF00D);
        #1;
        for (int n = 0; n < 8; n++) begin
            if (bus.frame_done) break;
            @(negedge clk); #1;
        end
        chk("clr.req1_done", 32'(bus.frame_done), 32'd1);
        chk("clr.req1_id", 32'(bus.done_id), 32'd1);
        wait_idle("clr.idle", 4);
        chk("clr.bank20", 32'(bank[20]), 32'h0D);
        chk("clr.bank23", 32'(bank[23]), 32'hCA);

        // req3 offers while busy, then withdraws.
        @(negedge clk);
        set_req(2, 1'b1, 3'd1, 32'h0D0C0B0A);
        #1 chk("wd.ready2", 32'(bus.req_ready), 32'b0100);
        r3_before = rdy3_cnt;
        w4_before = slot4_writes;
        @(negedge clk);
        set_req(2, 1'b0, 3'd1, 32'h0D0C0B0A);
        set_req(3, 1'b1, 3'd4, 32'h55667788);
        #1 chk("wd.ready_busy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        set_req(3, 1'b0, 3'd4, 32'h55667788);
        #1;
        wait_idle("wd.idle", 12);
        repeat (2) @(negedge clk);
        #1;
        chk("wd.no_ready3", 32'(rdy3_cnt - r3_before), 32'd0);
        chk("wd.no_write4", 32'(slot4_writes - w4_before), 32'd0);
        chk("wd.bank4", 32'(bank[4]), 32'h0A);
        chk("wd.bank7", 32'(bank[7]), 32'h0D);

        // Same slot: rr_ptr=3 so req1 goes first and req2 overwrites it.
        @(negedge clk);
        set_req(1, 1'b1, 3'd7, 32'hAAAAAAAA);
        set_req(2, 1'b1, 3'd7, 32'hBBBBBBBB);
        #1 chk("col.ready1", 32'(bus.req_ready), 32'b0010);
        last = cyc;
        @(negedge clk);
        set_req(1, 1'b0, 3'd7, 32'hAAAAAAAA);
        #1 wait_ready("col.ready2", 4'b0100, 12);
        chk("col.gap", 32'(cyc - last), 32'd6);
        @(negedge clk);
        set_req(2, 1'b0, 3'd7, 32'hBBBBBBBB);
        #1;
        wait_idle("col.idle", 12);
        for (int a = 28; a < 32; a++) chk($sformatf("col.bank%0d", a), 32'(bank[a]), 32'hBB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
